// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters,
// with SETUP/ACCESS sequencing and a wait-state timeout that aborts with an error response.
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLE  = 16
) (
  input  logic                              apb_clk_in,
  input  logic                              apb_rstn_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ-1:0]                req_write_in,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  output logic [NUM_REQ-1:0]                rsp_valid_out,
  output logic [APB_DATA_WIDTH-1:0]         rsp_rdata_out,
  output logic                              rsp_error_out,
  output logic [APB_ADDR_WIDTH-1:0]         apb_addr_out,
  output logic                              apb_psel_out,
  output logic                              apb_penable_out,
  output logic                              apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]         apb_wdata_out,
  input  logic [APB_DATA_WIDTH-1:0]         apb_rdata_in,
  input  logic                              apb_ready_in,
  input  logic                              apb_slverr_in
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLE + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [GW-1:0] last, last_nx, gnt, gnt_nx, pick, idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic found;
  logic [NUM_REQ-1:0] req_ready_nx, rsp_valid_nx;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_nx, wdata_nx;
  logic [APB_ADDR_WIDTH-1:0] addr_nx;
  logic rsp_error_nx, psel_nx, penable_nx, write_nx;

  // First valid requester strictly after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last) + i) % NUM_REQ);
      if (!found && req_valid_in[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    last_nx = last;
    gnt_nx = gnt;
    cnt_nx = cnt;
    req_ready_nx = '0;
    rsp_valid_nx = '0;
    rsp_rdata_nx = rsp_rdata_out;
    rsp_error_nx = rsp_error_out;
    addr_nx = apb_addr_out;
    write_nx = apb_write_out;
    wdata_nx = apb_wdata_out;
    psel_nx = apb_psel_out;
    penable_nx = apb_penable_out;
    case (state)
      IDLE: begin
        psel_nx = found;
        penable_nx = 1'b0;
        addr_nx = found ? req_addr_in[int'(pick)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] : '0;
        wdata_nx = found ? req_wdata_in[int'(pick)*APB_DATA_WIDTH +: APB_DATA_WIDTH] : '0;
        write_nx = found & req_write_in[pick];
        req_ready_nx = found ? NUM_REQ'(1) << pick : '0;
        gnt_nx = found ? pick : gnt;
        last_nx = found ? pick : last;
        state_nx = found ? SETUP : IDLE;
      end
      SETUP: begin
        penable_nx = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (apb_ready_in || cnt == CW'(TIMEOUT_CYCLE - 1)) begin
          rsp_rdata_nx = (apb_ready_in && !apb_write_out) ? apb_rdata_in : '0;
          rsp_error_nx = apb_ready_in ? apb_slverr_in : 1'b1;
          rsp_valid_nx = NUM_REQ'(1) << gnt;
          psel_nx = 1'b0;
          penable_nx = 1'b0;
          state_nx = RESP;
        end
        cnt_nx = apb_ready_in ? cnt : cnt + CW'(1);
      end
      default: begin
        cnt_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state <= IDLE;
      last <= GW'(NUM_REQ - 1);
      gnt <= '0;
      cnt <= '0;
      req_ready_out <= '0;
      rsp_valid_out <= '0;
      rsp_rdata_out <= '0;
      rsp_error_out <= 1'b0;
      apb_addr_out <= '0;
      apb_psel_out <= 1'b0;
      apb_penable_out <= 1'b0;
      apb_write_out <= 1'b0;
      apb_wdata_out <= '0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      gnt <= gnt_nx;
      cnt <= cnt_nx;
      req_ready_out <= req_ready_nx;
      rsp_valid_out <= rsp_valid_nx;
      rsp_rdata_out <= rsp_rdata_nx;
      rsp_error_out <= rsp_error_nx;
      apb_addr_out <= addr_nx;
      apb_psel_out <= psel_nx;
      apb_penable_out <= penable_nx;
      apb_write_out <= write_nx;
      apb_wdata_out <= wdata_nx;
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenario tests for apb_master_arbiter (4 requesters, timeout 16).
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [DW-1:0] prdata = '0;
  logic rsp_error, psel, penable, pwrite;
  logic pready = 1'b0, pslverr = 1'b0;
  logic [AW-1:0] paddr;
  logic [9:0] ctl, exp;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign ctl = {psel, penable, req_ready, rsp_valid};

  apb_master_arbiter #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLE(TO)) dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .req_valid_in(req_valid), .req_write_in(req_write), .req_addr_in(req_addr), .req_wdata_in(req_wdata),
    .req_ready_out(req_ready), .rsp_valid_out(rsp_valid), .rsp_rdata_out(rsp_rdata), .rsp_error_out(rsp_error),
    .apb_addr_out(paddr), .apb_psel_out(psel), .apb_penable_out(penable), .apb_write_out(pwrite),
    .apb_wdata_out(pwdata), .apb_rdata_in(prdata), .apb_ready_in(pready), .apb_slverr_in(pslverr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 10'b0); end
    n_cmp++; if ({paddr, pwdata, pwrite} !== '0) begin n_bad++; $display("FAIL reset_bus got=%h/%h/%b exp=0", paddr, pwdata, pwrite); end
    n_cmp++; if ({rsp_rdata, rsp_error} !== '0) begin n_bad++; $display("FAIL reset_rsp got=%h/%b exp=0", rsp_rdata, rsp_error); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_read;
    req_valid = 4'b0001;
    req_write = 4'b0000;
    req_addr[0*AW +: AW] = 32'h100;
    tick();
    exp = 10'b10_0001_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t1_setup got=%b exp=%b", ctl, exp); end
    n_cmp++; if ({paddr, pwrite} !== {32'h100, 1'b0}) begin n_bad++; $display("FAIL t1_addr got=%h/%b exp=100/0", paddr, pwrite); end
    req_valid = '0;
    pready = 1'b1;
    prdata = 32'hA5A5_0001;
    tick();
    exp = 10'b11_0000_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t1_access got=%b exp=%b", ctl, exp); end
    tick();
    exp = 10'b00_0000_0001;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t1_resp got=%b exp=%b", ctl, exp); end
    n_cmp++; if ({rsp_rdata, rsp_error} !== {32'hA5A5_0001, 1'b0}) begin n_bad++; $display("FAIL t1_rdata got=%h/%b exp=a5a50001/0", rsp_rdata, rsp_error); end
    tick();
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL t1_idle got=%b exp=%b", ctl, 10'b0); end
  endtask

  task automatic test_round_robin;
    logic [3:0] g;
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 4);
    req_write = '0;
    req_valid = 4'b1111;
    pready = 1'b1;
    prdata = 32'h0000_0B0B;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      tick();
      exp = {2'b10, g, 4'b0};
      n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t2_grant%0d got=%b exp=%b", k, ctl, exp); end
      n_cmp++; if (paddr !== 32'h1000 + 32'((k % 4) * 4)) begin n_bad++; $display("FAIL t2_addr%0d got=%h exp=%h", k, paddr, 32'h1000 + 32'((k % 4) * 4)); end
      tick();
      tick();
      exp = {6'b0, g};
      n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t2_resp%0d got=%b exp=%b", k, ctl, exp); end
      tick();
    end
    req_valid = '0;
    pready = 1'b0;
  endtask

  task automatic test_timeout;
    req_valid = 4'b0100;
    req_write = '0;
    req_addr[2*AW +: AW] = 32'h300;
    prdata = 32'hFFFF_0000;
    tick();
    exp = 10'b10_0100_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t4_grant got=%b exp=%b", ctl, exp); end
    req_valid = '0;
    tick();
    for (int c = 1; c < TO; c++) tick();
    exp = 10'b11_0000_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t4_still_access got=%b exp=%b", ctl, exp); end
    tick();
    exp = 10'b00_0000_0100;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t4_abort got=%b exp=%b", ctl, exp); end
    n_cmp++; if ({rsp_rdata, rsp_error} !== {32'h0, 1'b1}) begin n_bad++; $display("FAIL t4_err got=%h/%b exp=0/1", rsp_rdata, rsp_error); end
    tick();
  endtask

  task automatic test_write_wait;
    req_valid = 4'b0010;
    req_write = 4'b0010;
    req_addr[1*AW +: AW] = 32'h20;
    req_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    pready = 1'b0;
    prdata = 32'h1234_5678;
    tick();
    exp = 10'b10_0010_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t3_grant got=%b exp=%b", ctl, exp); end
    req_valid = '0;
    req_addr = '0;
    req_wdata = '0;
    req_write = '0;
    tick();
    for (int w = 0; w < 4; w++) begin
      n_cmp++; if ({ctl, paddr, pwdata, pwrite} !== {10'b11_0000_0000, 32'h20, 32'hDEAD_BEEF, 1'b1}) begin
        n_bad++; $display("FAIL t3_stable%0d got=%b/%h/%h/%b exp=1100000000/20/deadbeef/1", w, ctl, paddr, pwdata, pwrite);
      end
      if (w < 3) tick();
    end
    pready = 1'b1;
    tick();
    exp = 10'b00_0000_0010;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t3_resp got=%b exp=%b", ctl, exp); end
    n_cmp++; if ({rsp_rdata, rsp_error} !== {32'h0, 1'b0}) begin n_bad++; $display("FAIL t3_rdata got=%h/%b exp=0/0", rsp_rdata, rsp_error); end
    pready = 1'b0;
    tick();
  endtask

  task automatic test_slverr;
    req_valid = 4'b1000;
    req_write = '0;
    tick();
    req_valid = '0;
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 32'h55;
    tick();
    tick();
    exp = 10'b00_0000_1000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t5_slverr_resp got=%b exp=%b", ctl, exp); end
    n_cmp++; if ({rsp_rdata, rsp_error} !== {32'h55, 1'b1}) begin n_bad++; $display("FAIL t5_slverr got=%h/%b exp=55/1", rsp_rdata, rsp_error); end
    pslverr = 1'b0;
    pready = 1'b0;
    tick();
    req_valid = 4'b0001;
    tick();
    exp = 10'b10_0001_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t5_expire_grant got=%b exp=%b", ctl, exp); end
    req_valid = '0;
    prdata = 32'h77;
    tick();
    for (int c = 1; c < TO; c++) tick();
    pready = 1'b1;
    tick();
    exp = 10'b00_0000_0001;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t5_expire_resp got=%b exp=%b", ctl, exp); end
    n_cmp++; if ({rsp_rdata, rsp_error} !== {32'h77, 1'b0}) begin n_bad++; $display("FAIL t5_expire got=%h/%b exp=77/0", rsp_rdata, rsp_error); end
    pready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    n_cmp++; if ({ctl, paddr} !== '0) begin n_bad++; $display("FAIL t6_async got=%b/%h exp=0/0", ctl, paddr); end
    tick();
    @(negedge clk);
    rstn = 1'b1;
    req_valid = 4'b0011;
    tick();
    exp = 10'b10_0001_0000;
    n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL t6_req0_first got=%b exp=%b", ctl, exp); end
    req_valid = '0;
    pready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_timeout();
    test_write_wait();
    test_slverr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
